// File: rtl/serial_add16_ctrl_if.sv
// Operand/result bundle for the bit-serial adder controller.
// master drives the request, slave returns status and result.
interface serial_add16_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_add16_ctrl.sv
// Bit-serial add/sub controller driving one shared full adder,
// one operand bit pair per clock, LSB first.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add16_ctrl #(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  serial_add16_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_busy;
  logic             r_done;
  logic             r_co;
  logic             r_ov;

  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_word;

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_word = {w_s, r_res[WIDTH-1:1]};

  full_adder u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_c),
    .o_s (w_s),
    .o_c (w_co)
  );

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_co;
  assign bus.overflow  = r_ov;

  // Sequencer: latch on start, shift one bit per clock, publish at MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          r_res <= w_word;
          r_c   <= w_co;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_word;
            r_co    <= w_co;
            r_ov    <= r_c ^ w_co;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_c     <= bus.sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add16_ctrl.sv
// Scoreboard bench for serial_add16_ctrl: driver pushes model results,
// a negedge monitor pops them when done is seen.
module tb_serial_add16_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_add16_ctrl_if #(.WIDTH(W)) ifc ();

  serial_add16_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] held_sum = '0;
  logic         held_co = 1'b0;
  logic         held_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic sub,
                                 input int due);
    exp_t   e;
    longint sa, sb, ua, ub, res, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    lim = longint'(1) << (W - 1);
    res = sub ? sa - sb : sa + sb;
    e.ov  = (res > lim - 1) || (res < -lim);
    e.co  = sub ? (ua >= ub) : (ua + ub >= (lim << 1));
    e.sum = sub ? W'(ua - ub) : W'(ua + ub);
    e.due = due;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, got, exp, cyc);
    end
  endtask

  // Monitor: compare every cycle out of reset; consume on done.
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    if (rst_n) begin
      if (ifc.done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.due);
          held_sum = e.sum;
          held_co  = e.co;
          held_ov  = e.ov;
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing_done: got 0 expected 1 at cycle %0d", cyc);
        void'(q.pop_front());
      end
      exp_busy = (q.size() > 0) && (cyc >= q[0].due - W) && (cyc < q[0].due);
      chk("busy", ifc.busy, exp_busy);
      chk("sum", ifc.sum, held_sum);
      chk("carry_out", ifc.carry_out, held_co);
      chk("overflow", ifc.overflow, held_ov);
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic st);
    ifc.a     = a;
    ifc.b     = b;
    ifc.sub   = sub;
    ifc.start = st;
    if (st && rst_n && ifc.busy === 1'b0)
      q.push_back(model(a, b, sub, cyc + 1 + W));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic sub);
    drive(a, b, sub, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      idle();
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.start = 1'b1;
    ifc.sub   = 1'b0;
    ifc.a     = 16'hFFFF;
    ifc.b     = 16'h0000;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_done", ifc.done, 1'b0);
    chk("rst_sum", ifc.sum, 16'h0000);
    chk("rst_co", ifc.carry_out, 1'b0);
    chk("rst_ov", ifc.overflow, 1'b0);
    ifc.start = 1'b0;
    rst_n     = 1'b1;
    idle();

    op(16'h1234, 16'h0FFF, 1'b0); wait_idle();
    op(16'hFFFF, 16'h0001, 1'b0); wait_idle();
    op(16'h7FFF, 16'h0001, 1'b0); wait_idle();
    op(16'h0005, 16'h0007, 1'b1); wait_idle();
    op(16'h8000, 16'h0001, 1'b1); wait_idle();

    op(16'h0001, 16'h0001, 1'b0);
    repeat (4) idle();
    drive(16'hAAAA, W'($urandom), 1'b0, 1'b1);
    wait_idle();

    for (int i = 0; i < 4 * (W + 1); i++)
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    ifc.start = 1'b0;
    wait_idle();

    op(16'h1111, 16'h2222, 1'b0);
    repeat (7) idle();
    rst_n    = 1'b0;
    q.delete();
    held_sum = '0;
    held_co  = 1'b0;
    held_ov  = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", ifc.busy, 1'b0);
    chk("midrst_done", ifc.done, 1'b0);
    chk("midrst_sum", ifc.sum, 16'h0000);
    rst_n = 1'b1;
    idle();
    op(16'h0003, 16'h0004, 1'b0); wait_idle();

    for (int i = 0; i < 300; i++)
      drive(W'($urandom), W'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0);
    ifc.start = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
